// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART blocks.
// - rx_state_e : receiver FSM state encoding
// - PAR_*      : parity mode constants for the PARITY parameter
// - baud_div() : clocks per oversample tick (shared with the TX side)
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_WAIT_HI = 3'd5
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Truncating divide; never below one clock per tick.
  function automatic int baud_div(input int clk_hz, input int baud, input int ovs);
    int d;
    d = clk_hz / (baud * ovs);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_ovs_if.sv
// Host-side result bus of the UART receiver.
// - rx_data    : received payload
// - rx_valid   : one-cycle frame-complete strobe
// - parity_err / frame_err / break_det : status of the frame last strobed
interface uart_rx_ovs_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;

  modport master (output rx_data, rx_valid, parity_err, frame_err, break_det);
  modport slave  (input  rx_data, rx_valid, parity_err, frame_err, break_det);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator.
// - clk, rst_n : clock, async active-low reset (the only thing that resets the divider)
// - tick       : one-cycle pulse every baud_div(CLK_HZ, BAUD_RATE, OVS) clocks
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int OVS       = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int DIV = baud_div(CLK_HZ, BAUD_RATE, OVS);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with configurable frame format.
// - clk, rst_n : system clock, async active-low reset
// - rx         : asynchronous serial line, idle high
// - host       : result bus (data, valid strobe, parity/frame/break flags)
// Each bit is sampled at three consecutive ticks around its centre and the
// majority decides the value. Results are registered and held until the
// next completed frame.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  uart_rx_ovs_if.master host
);
  localparam int SW = $clog2(OVS);
  localparam int BW = 4;
  localparam logic [SW-1:0] SMP0  = SW'(OVS/2 - 1);
  localparam logic [SW-1:0] SMP1  = SW'(OVS/2);
  localparam logic [SW-1:0] VOTE  = SW'(OVS/2 + 1);
  localparam logic [SW-1:0] SLAST = SW'(OVS - 1);

  logic tick;

  uart_baud_tick #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD_RATE), .OVS(OVS)) u_tick (
    .clk(clk), .rst_n(rst_n), .tick(tick)
  );

  logic [1:0]           sync_q, sync_d;
  logic                 rxs_prev_q, rxs_prev_d;
  rx_state_e            state_q, state_d;
  logic [SW-1:0]        s_cnt_q, s_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic [1:0]           smp_q, smp_d;
  logic                 p_err_q, p_err_d, f_err_q, f_err_d, any1_q, any1_d;
  logic                 valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, brk_q, brk_d;
  logic                 rxs, vote, vote_pt, bit_end, exp_par, f_err_nx, any1_nx;

  assign rxs     = sync_q[1];
  assign vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
  assign vote_pt = tick && (s_cnt_q == VOTE);
  assign bit_end = tick && (s_cnt_q == SLAST);
  assign exp_par = (PARITY == PAR_ODD) ? ~^shift_q : ^shift_q;

  always_comb begin
    sync_d     = {sync_q[0], rx};
    rxs_prev_d = rxs;
    state_d    = state_q;
    s_cnt_d    = s_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    smp_d      = smp_q;
    p_err_d    = p_err_q;
    f_err_d    = f_err_q;
    any1_d     = any1_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    pe_d       = pe_q;
    fe_d       = fe_q;
    brk_d      = brk_q;
    f_err_nx   = f_err_q | ~vote;
    any1_nx    = any1_q | vote;

    if (tick && state_q != S_IDLE) begin
      s_cnt_d = (s_cnt_q == SLAST) ? '0 : s_cnt_q + 1'b1;
      if (s_cnt_q == SMP0) smp_d[0] = rxs;
      if (s_cnt_q == SMP1) smp_d[1] = rxs;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!rxs && rxs_prev_q) begin
          state_d = S_START;
          s_cnt_d = '0;
          p_err_d = 1'b0;
          f_err_d = 1'b0;
          any1_d  = 1'b0;
        end
      end
      S_START: begin
        if (vote_pt && vote) state_d = S_IDLE;   // glitch, not a start bit
        else if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (vote_pt) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          any1_d  = any1_nx;
        end
        if (bit_end) begin
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            state_d   = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (vote_pt) begin
          p_err_d = (vote != exp_par);
          any1_d  = any1_nx;
        end
        if (bit_end) begin
          state_d   = S_STOP;
          bit_cnt_d = '0;
        end
      end
      S_STOP: begin
        if (vote_pt) begin
          f_err_d = f_err_nx;
          any1_d  = any1_nx;
          // Report at the centre of the last stop bit so a following start
          // edge can be caught without an idle gap.
          if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            pe_d    = p_err_q;
            fe_d    = f_err_nx;
            brk_d   = f_err_nx & ~any1_nx;
            state_d = vote ? S_IDLE : S_WAIT_HI;
          end
        end
        if (bit_end) bit_cnt_d = bit_cnt_q + 1'b1;
      end
      S_WAIT_HI: begin
        // A held-low line must go high before a new start edge counts.
        if (tick && rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      rxs_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      s_cnt_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      smp_q      <= '0;
      p_err_q    <= 1'b0;
      f_err_q    <= 1'b0;
      any1_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      rxs_prev_q <= rxs_prev_d;
      state_q    <= state_d;
      s_cnt_q    <= s_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      smp_q      <= smp_d;
      p_err_q    <= p_err_d;
      f_err_q    <= f_err_d;
      any1_q     <= any1_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      brk_q      <= brk_d;
    end
  end

  assign host.rx_data    = data_q;
  assign host.rx_valid   = valid_q;
  assign host.parity_err = pe_q;
  assign host.frame_err  = fe_q;
  assign host.break_det  = brk_q;
endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs: four receivers with different frame formats, each on
// its own line. Every frame sent pushes its expected result; one compare
// process checks valid strobes, results, latency and flag hold every cycle.
module tb_uart_rx_ovs;
  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int OVS    = 16;
  localparam int BT     = 16;   // clocks per bit (one tick per clock)
  localparam int NI     = 4;

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
    int         t0;
    int         nbits;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rx_ln [NI];
  int   cfg_nb  [NI] = '{8, 8, 8, 7};
  int   cfg_par [NI] = '{0, 2, 1, 0};
  int   cfg_ns  [NI] = '{1, 1, 1, 2};

  logic [8:0] m_data [NI];
  logic       m_vld  [NI];
  logic       m_pe   [NI];
  logic       m_fe   [NI];
  logic       m_brk  [NI];

  exp_t       expq[$];
  logic [8:0] last_data [NI];
  logic       last_pe [NI], last_fe [NI], last_brk [NI];
  int         nvalid [NI] = '{0, 0, 0, 0};
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;

  uart_rx_ovs_if #(.DATA_BITS(8)) if0 ();
  uart_rx_ovs_if #(.DATA_BITS(8)) if1 ();
  uart_rx_ovs_if #(.DATA_BITS(8)) if2 ();
  uart_rx_ovs_if #(.DATA_BITS(7)) if3 ();

  uart_rx_ovs #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .OVS(OVS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u_8n1 (.clk(clk), .rst_n(rst_n), .rx(rx_ln[0]), .host(if0));
  uart_rx_ovs #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .OVS(OVS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    u_8e1 (.clk(clk), .rst_n(rst_n), .rx(rx_ln[1]), .host(if1));
  uart_rx_ovs #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .OVS(OVS), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    u_8o1 (.clk(clk), .rst_n(rst_n), .rx(rx_ln[2]), .host(if2));
  uart_rx_ovs #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .OVS(OVS), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
    u_7n2 (.clk(clk), .rst_n(rst_n), .rx(rx_ln[3]), .host(if3));

  assign m_data[0] = {1'b0, if0.rx_data};
  assign m_data[1] = {1'b0, if1.rx_data};
  assign m_data[2] = {1'b0, if2.rx_data};
  assign m_data[3] = {2'b0, if3.rx_data};
  assign m_vld[0] = if0.rx_valid;  assign m_pe[0] = if0.parity_err;
  assign m_vld[1] = if1.rx_valid;  assign m_pe[1] = if1.parity_err;
  assign m_vld[2] = if2.rx_valid;  assign m_pe[2] = if2.parity_err;
  assign m_vld[3] = if3.rx_valid;  assign m_pe[3] = if3.parity_err;
  assign m_fe[0] = if0.frame_err;  assign m_brk[0] = if0.break_det;
  assign m_fe[1] = if1.frame_err;  assign m_brk[1] = if1.break_det;
  assign m_fe[2] = if2.frame_err;  assign m_brk[2] = if2.break_det;
  assign m_fe[3] = if3.frame_err;  assign m_brk[3] = if3.break_det;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h want %0h (cycle %0d)", nm, inst, act, exp, cyc);
    end
  endtask

  // Parity bit a transmitter would send: odd mode makes the total count of
  // ones odd, even mode makes it even.
  function automatic logic model_pbit(input logic [8:0] d, input int par);
    int ones;
    ones = $countones(d);
    if (par == 1) return (ones % 2) == 0;
    return (ones % 2) == 1;
  endfunction

  // Call at a negedge; returns at a negedge. glitch_bit >= 0 inverts that
  // data bit for one clock near its centre.
  task automatic send_frame(input int idx, input logic [8:0] d, input bit flip,
                            input logic [1:0] stops, input int glitch_bit, input int gap);
    int nb, par, ns, total, p;
    logic [8:0] dm;
    logic pbit, fe, allz;
    logic fb [12];
    exp_t e;
    nb = cfg_nb[idx]; par = cfg_par[idx]; ns = cfg_ns[idx];
    dm = d & ((9'd1 << nb) - 9'd1);
    pbit = model_pbit(dm, par) ^ flip;
    total = 1 + nb + ((par != 0) ? 1 : 0) + ns;
    fb[0] = 1'b0;
    for (int k = 0; k < nb; k++) fb[1 + k] = dm[k];
    p = 1 + nb;
    if (par != 0) begin fb[p] = pbit; p++; end
    fe = 1'b0;
    allz = (dm == 9'd0) && !((par != 0) && pbit);
    for (int s = 0; s < ns; s++) begin
      fb[p + s] = stops[s];
      if (!stops[s]) fe = 1'b1; else allz = 1'b0;
    end
    e.inst = idx; e.data = dm; e.pe = (par != 0) && flip; e.fe = fe;
    e.brk = fe && allz; e.nbits = total; e.t0 = cyc;
    expq.push_back(e);
    for (int b = 0; b < total; b++) begin
      rx_ln[idx] = fb[b];
      for (int c = 0; c < BT; c++) begin
        if (glitch_bit >= 0 && b == glitch_bit + 1 && c == 8) rx_ln[idx] = ~fb[b];
        if (glitch_bit >= 0 && b == glitch_bit + 1 && c == 9) rx_ln[idx] = fb[b];
        @(negedge clk);
      end
    end
    rx_ln[idx] = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  exp_t ce;
  int   lat;
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        chk("reset_outputs", i, {m_data[i], m_vld[i], m_pe[i], m_fe[i], m_brk[i]}, 0);
        last_data[i] = '0; last_pe[i] = 0; last_fe[i] = 0; last_brk[i] = 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (m_vld[i]) begin
          nvalid[i]++;
          if (expq.size() == 0 || expq[0].inst != i) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_valid inst%0d: got valid data %0h want no valid (cycle %0d)", i, m_data[i], cyc);
          end else begin
            ce = expq.pop_front();
            chk("rx_data", i, m_data[i], ce.data);
            chk("parity_err", i, m_pe[i], ce.pe);
            chk("frame_err", i, m_fe[i], ce.fe);
            chk("break_det", i, m_brk[i], ce.brk);
            // Vote of the last stop bit lands about half a bit before the
            // frame ends, plus synchroniser delay.
            lat = cyc - ce.t0;
            chk("latency_in_window", i, (lat >= ce.nbits*BT - 9 && lat <= ce.nbits*BT - 1), 1);
            last_data[i] = ce.data; last_pe[i] = ce.pe; last_fe[i] = ce.fe; last_brk[i] = ce.brk;
          end
        end else begin
          chk("flags_hold", i, {m_data[i], m_pe[i], m_fe[i], m_brk[i]},
              {last_data[i], last_pe[i], last_fe[i], last_brk[i]});
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int idx, gap, n0;
    logic [8:0] d;
    bit fl;
    logic [1:0] st;
    exp_t be;

    foreach (rx_ln[i]) rx_ln[i] = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 8N1 0xA5
    send_frame(0, 9'h0A5, 0, 2'b11, -1, 4);
    chk("a5_data", 0, m_data[0], 9'h0A5);
    chk("a5_flags", 0, {m_pe[0], m_fe[0], m_brk[0]}, 3'b000);

    // 0x37 with even / odd parity, correct then flipped parity bit
    send_frame(1, 9'h037, 0, 2'b11, -1, 4);
    chk("8e1_good_perr", 1, m_pe[1], 1'b0);
    send_frame(1, 9'h037, 1, 2'b11, -1, 4);
    chk("8e1_bad_perr", 1, m_pe[1], 1'b1);
    chk("8e1_bad_data", 1, m_data[1], 9'h037);
    send_frame(2, 9'h037, 0, 2'b11, -1, 4);
    chk("8o1_good_perr", 2, m_pe[2], 1'b0);
    send_frame(2, 9'h037, 1, 2'b11, -1, 4);
    chk("8o1_bad_perr", 2, m_pe[2], 1'b1);
    chk("8o1_bad_data", 2, m_data[2], 9'h037);

    // 7N2 with second stop bit low
    send_frame(3, 9'h055, 0, 2'b01, -1, 8);
    chk("7n2_data", 3, m_data[3], 9'h055);
    chk("7n2_ferr_brk", 3, {m_fe[3], m_brk[3]}, 2'b10);

    // Break: 20 bit times low on 8N1, exactly one report
    n0 = nvalid[0];
    be.inst = 0; be.data = '0; be.pe = 0; be.fe = 1; be.brk = 1; be.nbits = 10; be.t0 = cyc;
    expq.push_back(be);
    rx_ln[0] = 1'b0;
    repeat (20*BT) @(negedge clk);
    rx_ln[0] = 1'b1;
    repeat (3*BT) @(negedge clk);
    chk("break_count", 0, nvalid[0] - n0, 1);
    chk("break_flags", 0, {m_data[0], m_fe[0], m_brk[0]}, {9'h000, 2'b11});
    send_frame(0, 9'h03C, 0, 2'b11, -1, 4);
    chk("after_break_data", 0, m_data[0], 9'h03C);

    // 3-clock low glitch on idle line
    n0 = nvalid[0];
    rx_ln[0] = 1'b0;
    repeat (3) @(negedge clk);
    rx_ln[0] = 1'b1;
    repeat (4*BT) @(negedge clk);
    chk("glitch_no_valid", 0, nvalid[0] - n0, 0);

    // One-clock spike in data bit 3 of 0x00 is outvoted
    send_frame(0, 9'h000, 0, 2'b11, 3, 4);
    chk("spike_data", 0, m_data[0], 9'h000);

    // Randomised frames across all formats
    for (int k = 0; k < 24; k++) begin
      idx = $urandom_range(0, NI-1);
      d   = 9'($urandom);
      fl  = (cfg_par[idx] != 0) && ($urandom_range(0, 3) == 0);
      st[0] = ($urandom_range(0, 4) != 0);
      st[1] = ($urandom_range(0, 4) != 0);
      gap = (st != 2'b11) ? $urandom_range(4, 20) : $urandom_range(0, 20);
      send_frame(idx, d, fl, st, -1, gap);
    end
    repeat (2*BT) @(negedge clk);

    // Back-to-back frames, then reset in the middle of a third
    n0 = nvalid[0];
    send_frame(0, 9'h001, 0, 2'b11, -1, 0);
    send_frame(0, 9'h0FE, 0, 2'b11, -1, 0);
    chk("b2b_count", 0, nvalid[0] - n0, 2);
    chk("b2b_data", 0, m_data[0], 9'h0FE);
    rx_ln[0] = 1'b0;                       // start + low bits of 0x3C
    repeat (3*BT + 5) @(negedge clk);
    n0 = nvalid[0];
    #3 rst_n = 1'b0;
    #1 chk("midreset_outputs", 0, {m_data[0], m_vld[0], m_pe[0], m_fe[0], m_brk[0]}, 0);
    rx_ln[0] = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    repeat (12*BT) @(negedge clk);
    chk("midreset_no_valid", 0, nvalid[0] - n0, 0);
    chk("queue_drained", 0, expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
